window_linebuffer: RTL and testbench

//  Parametrised streaming line buffer for the template-matching datapath. Takes a

---
 rtl/window_linebuffer.sv | 176 +++++++++++++++++
 tb/tb_window_linebuffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/window_linebuffer.sv
// Streaming line buffer: turns a raster pixel stream into WIN_H x WIN_W windows
// with their top-left coordinate. WIN_H-1 circular line memories hold the
// previous lines; a small shift array holds the last WIN_W columns.
//
// Handshake: a pixel is taken on a rising clk edge when ena & d_valid are both
// high and the block is either running a frame or sof marks pixel (0,0);
// win_valid/frame_done are single-cycle pulses with no back-pressure.
module window_linebuffer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN_W = 40,
  parameter int WIN_H = 40,
  parameter int PIX_W = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           sof,
  input  logic                           d_valid,
  input  logic [PIX_W-1:0]               d_in,
  output logic [WIN_W*WIN_H*PIX_W-1:0]   win_out,
  output logic                           win_valid,
  output logic [$clog2(IMG_W)-1:0]       win_x,
  output logic [$clog2(IMG_H)-1:0]       win_y,
  output logic                           frame_done,
  output logic [1:0]                     state_dbg
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int NL = WIN_H - 1;
  localparam int SW = (NL > 1) ? $clog2(NL) : 1;
  localparam int WB = WIN_W * WIN_H * PIX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [SW-1:0]   slot_q;        // y mod NL, tracked incrementally
  logic [WB-1:0]   win_out_q;
  logic            win_valid_q;
  logic [XW-1:0]   win_x_q;
  logic [YW-1:0]   win_y_q;
  logic            frame_done_q;

  logic [PIX_W-1:0] line_mem [NL][IMG_W];
  logic [PIX_W-1:0] win_q    [WIN_H][WIN_W];

  logic             accept;
  logic             take;
  logic             last_pix;
  logic             win_hit;
  logic [XW-1:0]    px;
  logic [YW-1:0]    py;
  logic [SW-1:0]    ps;
  logic [XW-1:0]    x_d;
  logic [YW-1:0]    y_d;
  logic [SW-1:0]    slot_d;
  logic [PIX_W-1:0] col_d [WIN_H];
  logic [PIX_W-1:0] win_d [WIN_H][WIN_W];
  logic [WB-1:0]    win_flat_d;
  logic [SW-1:0]    rd_slot;
  int               idx;

  assign win_out    = win_out_q;
  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

  // Current pixel coordinate, next counters, incoming column and shifted window
  always_comb begin
    accept = ena & d_valid;
    take   = accept & (sof | (state_q == S_RUN));
    // sof forces this pixel to (0,0) regardless of where the counters were
    px = sof ? '0 : x_q;
    py = sof ? '0 : y_q;
    ps = sof ? '0 : slot_q;
    last_pix = (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
    win_hit  = (px >= XW'(WIN_W - 1)) && (py >= YW'(WIN_H - 1));

    if (px == XW'(IMG_W - 1)) begin
      x_d    = '0;
      y_d    = (py == YW'(IMG_H - 1)) ? '0 : py + YW'(1);
      slot_d = (ps == SW'(NL - 1)) ? '0 : ps + SW'(1);
    end else begin
      x_d    = px + XW'(1);
      y_d    = py;
      slot_d = ps;
    end

    // Slot ps holds the oldest line (it is about to be overwritten); the
    // following slots, wrapping, hold progressively newer lines.
    idx     = 0;
    rd_slot = '0;
    for (int k = 0; k < NL; k++) begin
      idx = int'(ps) + k;
      if (idx >= NL) idx = idx - NL;
      rd_slot  = SW'(idx);
      col_d[k] = line_mem[rd_slot][px];
    end
    col_d[WIN_H-1] = d_in;

    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][WIN_W-1] = col_d[r];
    end

    win_flat_d = '0;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W; c++) begin
        win_flat_d[(r*WIN_W+c)*PIX_W +: PIX_W] = win_d[r][c];
      end
    end
  end

  // Frame FSM, raster counters and registered window outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      slot_q       <= '0;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (take) begin
        x_q          <= x_d;
        y_q          <= y_d;
        slot_q       <= slot_d;
        state_q      <= last_pix ? S_DONE : S_RUN;
        frame_done_q <= last_pix;
        if (win_hit) begin
          win_valid_q <= 1'b1;
          win_out_q   <= win_flat_d;
          win_x_q     <= px - XW'(WIN_W - 1);
          win_y_q     <= py - YW'(WIN_H - 1);
        end
      end
    end
  end

  // Line memory write; the read above sees the old value at this address
  always_ff @(posedge clk) begin
    if (take) begin
      line_mem[ps][px] <= d_in;
    end
  end

  // Window shift array: one new column per taken pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN_H; r++) begin
        for (int c = 0; c < WIN_W; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (take) begin
      win_q <= win_d;
    end
  end

endmodule

// File: tb/tb_window_linebuffer.sv
// Bench for window_linebuffer with an 8x6 image, 3x2 window, 8-bit pixels.
module tb_window_linebuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        sof = 1'b0;
  logic        d_valid = 1'b0;
  logic [7:0]  d_in = '0;
  logic [47:0] win_out;
  logic        win_valid;
  logic [2:0]  win_x;
  logic [2:0]  win_y;
  logic        frame_done;
  logic [1:0]  state_dbg;

  window_linebuffer #(
    .IMG_W(8), .IMG_H(6), .WIN_W(3), .WIN_H(2), .PIX_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .sof(sof), .d_valid(d_valid), .d_in(d_in),
    .win_out(win_out), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          m_run = 0;
  int          mx = 0;
  int          my = 0;
  int          cur_base = 0;
  logic [2:0]  hx = '0;
  logic [2:0]  hy = '0;
  logic [47:0] hwin = '0;
  int          win_cnt = 0;
  int          fd_cnt = 0;

  typedef struct {
    logic       rst, ena, sof, dv;
    logic [7:0] din;
    logic       wv;
    logic [2:0] ex, ey;
    logic       fd;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [47:0] exp_window(int wx, int wy, int base);
    logic [47:0] w;
    w = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'(base + (wy + r) * 8 + wx + c);
    return w;
  endfunction

  function automatic vec_t mk(logic r, logic e, logic s, logic v, logic [7:0] d,
                              logic wv, logic [2:0] ex, logic [2:0] ey, logic fd);
    vec_t t;
    t.rst = r; t.ena = e; t.sof = s; t.dv = v; t.din = d;
    t.wv = wv; t.ex = ex; t.ey = ey; t.fd = fd;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of inputs, model prediction, compare after the edge
  task automatic step(input logic r, input logic e, input logic s, input logic v,
                      input logic [7:0] d);
    logic ewv, efd;
    rst = r; ena = e; sof = s; d_valid = v; d_in = d;
    ewv = 0; efd = 0;
    if (r) begin
      m_run = 0; mx = 0; my = 0; hx = '0; hy = '0; hwin = '0;
    end else if (e && v) begin
      if (s) begin m_run = 1; mx = 0; my = 0; end
      if (m_run) begin
        if (mx >= 2 && my >= 1) begin
          ewv = 1; hx = 3'(mx - 2); hy = 3'(my - 1);
          hwin = exp_window(mx - 2, my - 1, cur_base);
        end
        if (mx == 7 && my == 5) begin efd = 1; m_run = 0; end
        if (mx == 7) begin mx = 0; my = (my == 5) ? 0 : my + 1; end
        else mx = mx + 1;
      end
    end
    @(posedge clk); #1;
    if (win_valid === 1'b1) win_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    check("win_valid", win_valid, ewv);
    check("frame_done", frame_done, efd);
    check("win_x", win_x, hx);
    check("win_y", win_y, hy);
    check("win_out", win_out, hwin);
  endtask

  // send pixels first..last of a frame, optionally with random non-accept gaps
  task automatic send_pixels(input int base, input int first, input int last, input bit gaps);
    for (int p = first; p <= last; p++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 0) begin
          case ($urandom_range(0, 2))
            0:       step(0, 0, 1'($urandom_range(0, 1)), 1, 8'($urandom_range(0, 255)));
            1:       step(0, 1, 1'($urandom_range(0, 1)), 0, 8'($urandom_range(0, 255)));
            default: step(0, 0, 1'($urandom_range(0, 1)), 0, 8'($urandom_range(0, 255)));
          endcase
        end
      end
      if (p == 0) cur_base = base;
      step(0, 1, (p == 0), 1, 8'(base + p));
    end
  endtask

  initial begin
    logic [47:0] t_hold;

    // table: reset, pre-sof drops, ignored sof without valid, first windows
    tbl[0]  = mk(1, 0, 0, 0, 8'd0,  0, 3'd0, 3'd0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 8'd99, 0, 3'd0, 3'd0, 0);
    tbl[2]  = mk(0, 1, 0, 1, 8'd98, 0, 3'd0, 3'd0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 8'd0,  0, 3'd0, 3'd0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 8'd0,  0, 3'd0, 3'd0, 0);
    for (int i = 5; i <= 13; i++) tbl[i] = mk(0, 1, 0, 1, 8'(i - 4), 0, 3'd0, 3'd0, 0);
    tbl[14] = mk(0, 0, 0, 1, 8'd10, 0, 3'd0, 3'd0, 0);
    tbl[15] = mk(0, 1, 0, 1, 8'd10, 1, 3'd0, 3'd0, 0);
    tbl[16] = mk(0, 1, 0, 0, 8'd55, 0, 3'd0, 3'd0, 0);
    tbl[17] = mk(0, 1, 0, 1, 8'd11, 1, 3'd1, 3'd0, 0);
    tbl[18] = mk(0, 1, 0, 1, 8'd12, 1, 3'd2, 3'd0, 0);

    t_hold = '0;
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; ena = tbl[i].ena; sof = tbl[i].sof;
      d_valid = tbl[i].dv; d_in = tbl[i].din;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), win_valid, tbl[i].wv);
      check($sformatf("tbl%0d_done", i), frame_done, tbl[i].fd);
      check($sformatf("tbl%0d_x", i), win_x, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), win_y, tbl[i].ey);
      if (tbl[i].wv) t_hold = exp_window(tbl[i].ex, tbl[i].ey, 0);
      check($sformatf("tbl%0d_win", i), win_out, t_hold);
      if (i == 0) check("reset_state", state_dbg, 2'd0);
    end

    // full frame, continuous valid
    step(1, 0, 0, 0, 8'd0);
    win_cnt = 0; fd_cnt = 0;
    send_pixels(0, 0, 47, 0);
    check("t1_windows", win_cnt, 30);
    check("t1_frame_done", fd_cnt, 1);
    check("t1_last_x", win_x, 3'd5);
    check("t1_last_y", win_y, 3'd4);
    check("t1_state_done", state_dbg, 2'd2);
    // pixels without sof after the frame are dropped
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'(77 + i));

    // random valid/ena gaps
    win_cnt = 0; fd_cnt = 0;
    send_pixels(0, 0, 47, 1);
    check("t2_windows", win_cnt, 30);
    check("t2_frame_done", fd_cnt, 1);

    // sof re-asserted at pixel (4,3)
    win_cnt = 0; fd_cnt = 0;
    send_pixels(0, 0, 27, 0);
    send_pixels(100, 0, 47, 0);
    check("t4_windows", win_cnt, 44);
    check("t4_frame_done", fd_cnt, 1);

    // reset mid-frame at (5,2)
    send_pixels(0, 0, 20, 0);
    step(1, 1, 0, 1, 8'd21);
    check("t5_state_idle", state_dbg, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 8'(22 + i));
    check("t5_still_idle", state_dbg, 2'd0);
    win_cnt = 0; fd_cnt = 0;
    send_pixels(0, 0, 47, 0);
    check("t5_windows", win_cnt, 30);
    check("t5_frame_done", fd_cnt, 1);

    // back-to-back frames
    win_cnt = 0; fd_cnt = 0;
    send_pixels(0, 0, 47, 0);
    check("t6_f1_windows", win_cnt, 30);
    check("t6_f1_done", fd_cnt, 1);
    win_cnt = 0; fd_cnt = 0;
    send_pixels(150, 0, 47, 0);
    check("t6_f2_windows", win_cnt, 30);
    check("t6_f2_done", fd_cnt, 1);
    step(0, 0, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
